mem_arbiter: RTL and testbench

- Shares the single-read-port / single-write-port `mem` between the Qrisc32 instruction-fetch (IF) and load/store (LS) requesters.
- Arbitrates the read port using LS priority, with a starvation guard for IF.
- Passes LS writes straight through, with a read-after-write hazard check.
- Routes the 1-cycle-latency read data back to the requester that owns it, and latches memory access faults.
- Sits between the CPU pipeline stages and the `mem` instance.

---
 rtl/qrisc_mem_pkg.sv | 22 ++
 rtl/mem_arbiter_if.sv | 52 +++++
 rtl/mem_arbiter_starve_cnt.sv | 29 ++
 rtl/mem_arbiter.sv | 121 ++++++++++++
 tb/tb_mem_arbiter.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/qrisc_mem_pkg.sv
// Shared types for the Qrisc32 memory arbiter.
//   word_t       : 32-bit memory word / byte address
//   rd_owner_t   : which requester owns the read data returning next cycle
//   WORD_ADR_LSB : first bit of the word address inside a byte address
//   same_word()  : true when two byte addresses hit the same 32-bit word
package qrisc_mem_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_LS   = 2'd2
    } rd_owner_t;

    localparam int WORD_ADR_LSB = 2;

    function automatic logic same_word(input word_t a, input word_t b);
        return a[31:WORD_ADR_LSB] == b[31:WORD_ADR_LSB];
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the CPU requesters (IF, LS), the arbiter and mem.
//   slave  : arbiter view (takes requests and mem responses, drives grants,
//            read data back to the CPU, mem command and fault status)
//   master : environment view (CPU stages + mem instance)
interface mem_arbiter_if #(
    parameter int ERR_CNT_W = 8
);
    import qrisc_mem_pkg::*;

    // instruction fetch
    logic                 if_rd;
    word_t                if_add;
    logic                 if_req;
    logic                 if_valid;
    word_t                if_data;
    // load/store
    logic                 ls_rd;
    logic                 ls_wr;
    word_t                ls_add_r;
    word_t                ls_add_w;
    word_t                ls_data_w;
    logic                 ls_req;
    logic                 ls_valid;
    word_t                ls_data;
    // memory side
    word_t                m_add_r;
    word_t                m_add_w;
    word_t                m_data_w;
    logic                 m_rd;
    logic                 m_wr;
    word_t                m_data_r;
    logic                 m_req;
    logic                 m_stop_active;
    // fault status
    logic                 err;
    logic [ERR_CNT_W-1:0] err_cnt;

    modport slave (
        input  if_rd, if_add, ls_rd, ls_wr, ls_add_r, ls_add_w, ls_data_w,
               m_data_r, m_req, m_stop_active,
        output if_req, if_valid, if_data, ls_req, ls_valid, ls_data,
               m_add_r, m_add_w, m_data_w, m_rd, m_wr, err, err_cnt
    );

    modport master (
        output if_rd, if_add, ls_rd, ls_wr, ls_add_r, ls_add_w, ls_data_w,
               m_data_r, m_req, m_stop_active,
        input  if_req, if_valid, if_data, ls_req, ls_valid, ls_data,
               m_add_r, m_add_w, m_data_w, m_rd, m_wr, err, err_cnt
    );

endinterface

// File: rtl/mem_arbiter_starve_cnt.sv
// Saturating up-counter with synchronous clear.
//   clk, reset : clock, synchronous active-high reset
//   inc        : count up one (held at LIMIT once reached)
//   clr        : return to zero (wins over inc)
//   cnt        : current count
//   at_lim     : cnt == LIMIT
// Used both as the IF starvation counter and as the fault counter.
module starve_cnt #(
    parameter int           W     = 4,
    parameter logic [W-1:0] LIMIT = '1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         at_lim
);

    assign at_lim = (cnt == LIMIT);

    always_ff @(posedge clk) begin
        if (reset || clr)
            cnt <= '0;
        else if (inc && !at_lim)
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Read/write port arbiter between Qrisc32 IF and LS stages and mem.
//   clk, reset : clock, synchronous active-high reset
//   bus        : slave side of mem_arbiter_if (requests, grants, mem command,
//                returned read data, fault flag and counter)
// LS owns the read port unless IF has been refused STARVE_LIMIT cycles in a
// row. LS writes go straight through; a read to the word being written in
// the same cycle is held off one cycle since mem would return stale data.
// Read data come back one cycle after the grant and are steered by rd_owner.
module mem_arbiter
    import qrisc_mem_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int ERR_CNT_W    = 8
) (
    input  logic           clk,
    input  logic           reset,
    mem_arbiter_if.slave   bus
);

    logic      if_gnt, ls_gnt, wr_go, hazard;
    word_t     rd_add;
    logic      starve_lim;
    rd_owner_t owner_q, owner_nxt;
    word_t     if_hold, ls_hold;
    logic      err_q;
    logic [ERR_CNT_W-1:0] err_cnt_q;
    logic [3:0] unused_starve_val;
    logic       unused_err_sat;

    // ---------------- grant ----------------
    // Reset is folded into "busy" so nothing reaches mem while reset is high.
    always_comb begin
        if_gnt = 1'b0;
        ls_gnt = 1'b0;
        wr_go  = 1'b0;
        if (!reset && !bus.m_req) begin
            wr_go = bus.ls_wr;
            if (bus.ls_rd && !(bus.if_rd && starve_lim))
                ls_gnt = 1'b1;
            else if (bus.if_rd)
                if_gnt = 1'b1;
        end
        rd_add = if_gnt ? bus.if_add : bus.ls_add_r;
        // The read is dropped, not redirected to the other requester.
        hazard = wr_go && (if_gnt || ls_gnt) && same_word(rd_add, bus.ls_add_w);
        if (hazard) begin
            if_gnt = 1'b0;
            ls_gnt = 1'b0;
        end
    end

    assign bus.m_rd     = if_gnt | ls_gnt;
    assign bus.m_add_r  = rd_add;
    assign bus.m_wr     = wr_go;
    assign bus.m_add_w  = bus.ls_add_w;
    assign bus.m_data_w = bus.ls_data_w;
    assign bus.if_req   = bus.if_rd & ~if_gnt;
    assign bus.ls_req   = (bus.ls_rd & ~ls_gnt) | (bus.ls_wr & ~wr_go);

    starve_cnt #(.W(4), .LIMIT(4'(STARVE_LIMIT))) u_starve (
        .clk    (clk),
        .reset  (reset),
        .inc    (bus.if_rd & ~if_gnt),
        .clr    (~bus.if_rd | if_gnt),
        .cnt    (unused_starve_val),
        .at_lim (starve_lim)
    );

    // ---------------- read data ownership ----------------
    always_ff @(posedge clk) begin
        if (reset)
            owner_q <= OWN_NONE;
        else
            owner_q <= owner_nxt;
    end

    always_comb begin
        owner_nxt = OWN_NONE;
        if (if_gnt)
            owner_nxt = OWN_IF;
        else if (ls_gnt)
            owner_nxt = OWN_LS;
    end

    // Holding registers keep each side's data stable while the other owns mem.
    always_ff @(posedge clk) begin
        if (reset) begin
            if_hold <= '0;
            ls_hold <= '0;
        end else begin
            if (owner_q == OWN_IF) if_hold <= bus.m_data_r;
            if (owner_q == OWN_LS) ls_hold <= bus.m_data_r;
        end
    end

    assign bus.if_valid = (owner_q == OWN_IF);
    assign bus.ls_valid = (owner_q == OWN_LS);
    assign bus.if_data  = (owner_q == OWN_IF) ? bus.m_data_r : if_hold;
    assign bus.ls_data  = (owner_q == OWN_LS) ? bus.m_data_r : ls_hold;

    // ---------------- faults ----------------
    always_ff @(posedge clk) begin
        if (reset)
            err_q <= 1'b0;
        else if (bus.m_stop_active)
            err_q <= 1'b1;
    end

    starve_cnt #(.W(ERR_CNT_W)) u_err_cnt (
        .clk    (clk),
        .reset  (reset),
        .inc    (bus.m_stop_active),
        .clr    (1'b0),
        .cnt    (err_cnt_q),
        .at_lim (unused_err_sat)
    );

    assign bus.err     = err_q;
    assign bus.err_cnt = err_cnt_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
    import qrisc_mem_pkg::*;

    localparam int LIMIT  = 4;
    localparam int EW     = 8;
    localparam int CNTMAX = (1 << EW) - 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ERR_CNT_W(EW)) bus();

    mem_arbiter #(.STARVE_LIMIT(LIMIT), .ERR_CNT_W(EW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // memory environment: 64 words, registered read, read-before-write
    word_t mem [64];
    always @(posedge clk) begin
        if (bus.m_wr) mem[bus.m_add_w[7:2]] <= bus.m_data_w;
        if (bus.m_rd) bus.m_data_r <= mem[bus.m_add_r[7:2]];
    end

    int n_vec = 0;
    int n_err = 0;

    // reference state
    int        starve   = 0;
    rd_owner_t p_own    = OWN_NONE;
    word_t     p_data   = '0;
    word_t     e_if_h   = '0;
    word_t     e_ls_h   = '0;
    bit        e_err    = 1'b0;
    int        e_cnt    = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit ifr, input word_t ifa, input bit lr, input bit lw,
                         input word_t lar, input word_t law, input word_t ld,
                         input bit mreq, input bit stop);
        bus.if_rd = ifr;      bus.if_add = ifa;
        bus.ls_rd = lr;       bus.ls_wr = lw;
        bus.ls_add_r = lar;   bus.ls_add_w = law;   bus.ls_data_w = ld;
        bus.m_req = mreq;     bus.m_stop_active = stop;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Called at a negedge with inputs already driven: checks the cycle against
    // the reference, advances the reference, and returns at the next negedge.
    task automatic step();
        bit        busy, wr;
        rd_owner_t g;
        word_t     a;
        #1;
        busy = reset || bus.m_req;
        wr   = bus.ls_wr && !busy;
        g    = OWN_NONE;
        if (!busy) begin
            if (bus.ls_rd && !(bus.if_rd && starve == LIMIT)) g = OWN_LS;
            else if (bus.if_rd)                               g = OWN_IF;
        end
        a = (g == OWN_IF) ? bus.if_add : bus.ls_add_r;
        if (g != OWN_NONE && wr && (a >> 2) == (bus.ls_add_w >> 2)) g = OWN_NONE;

        chk("m_rd", bus.m_rd, g != OWN_NONE);
        if (g != OWN_NONE) chk("m_add_r", bus.m_add_r, a);
        chk("m_wr", bus.m_wr, wr);
        if (wr) begin
            chk("m_add_w", bus.m_add_w, bus.ls_add_w);
            chk("m_data_w", bus.m_data_w, bus.ls_data_w);
        end
        chk("if_req", bus.if_req, bus.if_rd && g != OWN_IF);
        chk("ls_req", bus.ls_req, (bus.ls_rd && g != OWN_LS) || (bus.ls_wr && !wr));
        chk("if_valid", bus.if_valid, p_own == OWN_IF);
        chk("if_data", bus.if_data, (p_own == OWN_IF) ? p_data : e_if_h);
        chk("ls_valid", bus.ls_valid, p_own == OWN_LS);
        chk("ls_data", bus.ls_data, (p_own == OWN_LS) ? p_data : e_ls_h);
        chk("err", bus.err, e_err);
        chk("err_cnt", bus.err_cnt, e_cnt);

        if (p_own == OWN_IF) e_if_h = p_data;
        if (p_own == OWN_LS) e_ls_h = p_data;
        if (g != OWN_NONE) p_data = mem[a[7:2]];
        p_own = g;
        if (bus.if_rd && g != OWN_IF) starve = (starve < LIMIT) ? starve + 1 : LIMIT;
        else                          starve = 0;
        if (bus.m_stop_active) begin
            e_err = 1'b1;
            if (e_cnt < CNTMAX) e_cnt++;
        end
        if (reset) begin
            starve = 0; p_own = OWN_NONE; e_err = 1'b0; e_cnt = 0;
            e_if_h = '0; e_ls_h = '0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        idle();
        bus.m_data_r = '0;
        @(negedge clk);
        step();
        step();
        reset = 1'b0;

        // preload mem[4] through the write path, then a lone fetch of it
        drive(0, 0, 0, 1, 0, 32'h10, 32'hDEADBEEF, 0, 0); step();
        idle(); step();
        drive(1, 32'h10, 0, 0, 0, 0, 0, 0, 0);
        #1; chk("lone_m_rd", bus.m_rd, 1); chk("lone_if_req", bus.if_req, 0);
        step();
        idle();
        #1; chk("lone_if_data", bus.if_data, 32'hDEADBEEF); chk("lone_ls_valid", bus.ls_valid, 0);
        step();

        // contention: LS x4, then IF once the starve limit is reached, then LS
        drive(1, 32'h40, 1, 0, 32'h44, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            #1; chk("contend_req", {bus.if_req, bus.ls_req}, (i == 4) ? 2'b01 : 2'b10);
            step();
        end
        idle(); step();

        // RAW hazard on word 0x20
        drive(1, 32'h20, 0, 1, 0, 32'h20, 32'h12345678, 0, 0);
        #1; chk("raw_m_wr", bus.m_wr, 1); chk("raw_m_rd", bus.m_rd, 0); chk("raw_if_req", bus.if_req, 1);
        step();
        drive(1, 32'h20, 0, 0, 0, 0, 0, 0, 0);
        #1; chk("raw_retry_m_rd", bus.m_rd, 1);
        step();
        idle();
        #1; chk("raw_if_data", bus.if_data, 32'h12345678);
        step();

        // memory busy for two cycles
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h30, 0, 1, 0, 32'h80, 32'hA5A5_0000 + i, i < 2, 0);
            #1;
            chk("busy_m_rd", bus.m_rd, i == 2);
            chk("busy_m_wr", bus.m_wr, i == 2);
            chk("busy_if_req", bus.if_req, i < 2);
            chk("busy_ls_req", bus.ls_req, i < 2);
            step();
        end
        idle(); step();

        // faults: three pulses, then saturation, then reset
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0, 1); step();
            idle(); step();
        end
        #1; chk("flt_err", bus.err, 1); chk("flt_cnt3", bus.err_cnt, 3);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        repeat (300) step();
        idle();
        #1; chk("flt_sat", bus.err_cnt, 8'hFF);
        reset = 1'b1; step(); reset = 1'b0;
        #1; chk("flt_rst_err", bus.err, 0); chk("flt_rst_cnt", bus.err_cnt, 0);

        // reset right after an LS read grant
        drive(0, 0, 1, 0, 32'h10, 0, 0, 0, 0); step();
        reset = 1'b1; step(); reset = 1'b0;
        idle();
        #1; chk("rst_ls_valid", bus.ls_valid, 0); chk("rst_ls_data", bus.ls_data, 0);
        chk("rst_m_rd", bus.m_rd, 0);
        step();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            word_t ifa, lar, law;
            ifa = word_t'($urandom_range(0, 255));
            lar = word_t'($urandom_range(0, 255));
            law = word_t'($urandom_range(0, 255));
            case ($urandom_range(0, 3))
                0: law = ifa;
                1: law = lar;
                default: ;
            endcase
            drive($urandom_range(0, 2) != 0, ifa, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 2) == 0, lar, law, $urandom,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0);
            reset = ($urandom_range(0, 63) == 0);
            step();
        end
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
